// File: rtl/bit_serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the FSM state encoding and the default operand width.
package bit_serial_adder_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bit_serial_adder_full_adder_bit.sv
// One-bit full adder built from two half-adder stages and an OR.
// Purely combinational; used as the per-bit cell of the serial adder.
module full_adder_bit (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic co
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    assign w_s1 = x ^ y;
    assign w_c1 = x & y;

    assign s    = w_s1 ^ cin;
    assign w_c2 = w_s1 & cin;

    assign co   = w_c1 | w_c2;

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder cell per clock.
// Define BIT_SERIAL_ADDER_SUB_EN to add the 'sub' port (a - b mode).
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef BIT_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_c;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_s;
    logic             w_co;
    logic             w_sub;
    logic [WIDTH-1:0] w_acc;

`ifdef BIT_SERIAL_ADDER_SUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    assign w_accept = start &&
                      (r_state == IDLE || r_state == DONE);
    assign w_last   = (r_cnt == LAST);

    full_adder_bit u_fa (
        .x   (r_a[0]),
        .y   (r_b[0]),
        .cin (r_c),
        .s   (w_s),
        .co  (w_co)
    );

    // New sum bit enters at the MSB; bit 0 falls out after WIDTH shifts.
    assign w_acc = {w_s, r_sh};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; start is only honoured in IDLE and DONE.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    w_next = start ? SHIFT : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand load, serial datapath and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_sh   <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= w_sub ? ~b : b;
            r_c   <= w_sub;
            r_cnt <= '0;
        end else if (r_state == SHIFT) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_c   <= w_co;
            r_sh  <= w_acc[WIDTH-1:1];
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
                r_sum  <= w_acc;
                r_cout <= w_co;
            end
        end
    end

    assign busy = (r_state == SHIFT);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder (WIDTH=8).
// Define BIT_SERIAL_ADDER_SUB_EN to also exercise subtraction.
module tb_bit_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks   = 0;
    int failures = 0;

    logic [W:0] exp_q[$];

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef BIT_SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     nm, act, exp);
        end
    endtask

    // Monitor: each done pulse pops one expected {cout,sum}.
    always @(negedge clk) begin
        logic [W:0] e;
        if (rst === 1'b0 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got {cout,sum}=0x%0h expected no result",
                         {cout, sum});
            end else begin
                e = exp_q.pop_front();
                chk("result", {23'b0, cout, sum}, {23'b0, e});
            end
        end
    end

    // Start is raised just after edge t0 and accepted at t0+1;
    // done must be seen right after edge t0+W+1, busy for W cycles.
    task automatic run_op(input logic [W-1:0] ta,
                          input logic [W-1:0] tb_v,
                          input logic       ts,
                          input logic [W:0] exp,
                          input logic       pulse,
                          input logic       hold_chk,
                          input logic [W:0] hold,
                          input string      nm);
        int n;
        int bc;
        bit seen;
        exp_q.push_back(exp);
        a     = ta;
        b     = tb_v;
        sub   = ts;
        start = 1'b1;
        n     = 0;
        bc    = 0;
        seen  = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) start = 1'b0;
            if (pulse && n == 3) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'hFF;
            end
            if (pulse && n == 4) start = 1'b0;
            if (busy) bc++;
            if (done) seen = 1'b1;
            else if (hold_chk)
                chk({nm, "_hold"}, {23'b0, cout, sum},
                    {23'b0, hold});
        end
        chk({nm, "_latency"}, n, W + 1);
        chk({nm, "_busy_cycles"}, bc, W);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        sub   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_sum",  {24'b0, sum},  0);
        chk("rst_cout", {31'b0, cout}, 0);

        run_op(8'h5A, 8'h3C, 1'b0, 9'h096, 0, 0, 9'h0, "add_5a_3c");
        idle();
        run_op(8'hFF, 8'h01, 1'b0, 9'h100, 0, 0, 9'h0, "add_ff_01");
        idle();
        run_op(8'h00, 8'h00, 1'b0, 9'h000, 0, 0, 9'h0, "add_00_00");
        idle();
        run_op(8'h12, 8'h34, 1'b0, 9'h046, 1, 0, 9'h0, "ignore_start");
        idle();

        // Reset during the 4th SHIFT cycle discards the operation.
        a     = 8'h80;
        b     = 8'h80;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_busy", {31'b0, busy}, 0);
        chk("midrst_done", {31'b0, done}, 0);
        chk("midrst_sum",  {24'b0, sum},  0);
        chk("midrst_cout", {31'b0, cout}, 0);
        idle();
        run_op(8'h01, 8'h02, 1'b0, 9'h003, 0, 0, 9'h0, "after_rst");
        idle();

        // Back-to-back: second start issued in the DONE cycle.
        run_op(8'h21, 8'h43, 1'b0, 9'h064, 0, 0, 9'h0, "b2b_first");
        run_op(8'h7F, 8'h01, 1'b0, 9'h080, 0, 1, 9'h064, "b2b_second");
        idle();

`ifdef BIT_SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h01, 1'b1, 9'h10F, 0, 0, 9'h0, "sub_10_01");
        idle();
        run_op(8'h01, 8'h02, 1'b1, 9'h0FF, 0, 0, 9'h0, "sub_01_02");
        idle();
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
